fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of `decode`. Holds the PC, issues word reads to instruction memory over a valid/data_ok handshake, and presents `f_d_reg_t` (instruction, pc_plus_4) to decode. Includes a one-entry skid buffer for downstream stalls and a discard path for branch redirects that arrive while a memory read is in flight. Branches resolve in execute and have no delay slot, so every younger fetched instruction is flushed on redirect.

## Interface
- `PC_RESET`, default 32'hBFC0_0000, first fetch address after reset (word aligned)
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `ireq_valid`  out  1  read request to instruction memory
- `ireq_addr`  out  32  read address; bits [1:0] always 00
- `iresp_data_ok`  in  1  read data valid; completes the outstanding request
- `iresp_data`  in  32  instruction word, valid with `iresp_data_ok`
- `stall`  in  1  decode cannot accept this cycle (hazard unit)
- `redirect_valid`  in  1  taken-branch pulse from execute
- `redirect_pc`  in  32  branch target; bits [1:0] ignored (forced 00)
- `f_d_reg`  out  f_d_reg_t  {instruction, pc_plus_4} to decode
- `f_d_valid`  out  1  `f_d_reg` holds a real instruction

## Operation
- Registers: `pc`, `stale_addr`, output buffer (valid, instr, pc+4), skid buffer (valid, instr, pc+4), 2-bit state.
- Memory protocol: once `ireq_valid`=1, `ireq_addr` stays stable until a cycle with `iresp_data_ok`=1. `data_ok` may arrive in the request cycle (zero wait). `data_ok` without a pending request never occurs.
- Output is consumed at a clock edge when `f_d_valid`=1 and `stall`=0.
- When `f_d_valid`=0, `f_d_reg.instruction`=32'h0 (NOP bubble) and `pc_plus_4` keeps its last value.
- FETCH: `ireq_valid`=1, `ireq_addr`=`pc`.
  - On `data_ok`: if the output buffer is empty or being consumed, data goes to the output buffer with pc_plus_4=`pc`+4; otherwise it goes to the skid buffer and the state moves to HOLD. In both cases `pc` <= `pc`+4.
- HOLD: `ireq_valid`=0. When `stall`=0, the output buffer loads from the skid buffer, the skid buffer empties, and the state returns to FETCH.
- DISCARD: `ireq_valid`=1, `ireq_addr`=`stale_addr`. On `data_ok` the data is dropped and the state moves to FETCH.
- Redirect (any state) has highest priority, over `stall` and `data_ok`:
  - Output and skid buffers are invalidated.
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - If a request is pending and `data_ok`=0 this cycle (FETCH, or DISCARD), `stale_addr` <= current `ireq_addr` and the state moves to DISCARD. Otherwise the state moves to FETCH.
  - A redirect inside DISCARD updates `pc` only and keeps `stale_addr`.
- Arithmetic: `pc`+4 is 32-bit modulo (0xFFFF_FFFC wraps to 0x0000_0000). No misalignment exceptions.

## Timing
- Reset values (async, immediate): `pc`=`PC_RESET`, state FETCH, both buffers invalid, `f_d_reg.instruction`=0, `f_d_reg.pc_plus_4`=0, `f_d_valid`=0, `ireq_valid`=0 while `reset`=1.
- First request: `ireq_addr`=`PC_RESET` in the first cycle after reset deasserts.
- Latency: `data_ok` in cycle t gives `f_d_valid`=1 in cycle t+1.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Stall with an empty skid buffer: one more read may complete into the skid buffer, then requests stop (HOLD).
- Redirect in cycle t: `f_d_valid`=0 in cycle t+1. The target address is requested in t+1 if no stale read is pending; otherwise it is requested the cycle after the stale `data_ok`.
- Reset mid-transaction: all state clears immediately. Any later `data_ok` for the aborted read is the memory's responsibility and is not tracked.

## Test plan
- Reset release, zero-wait memory returning addr as data: requests 0xBFC00000, 0xBFC00004, …; `f_d_valid` rises one cycle after the first `data_ok` with instruction 0xBFC00000 and pc_plus_4 0xBFC00004. One instruction per cycle after that.
- `stall` held 3 cycles with zero-wait memory: exactly one extra word enters the skid buffer, then `ireq_valid`=0. After release, instructions appear in order with no loss or duplication.
- 2-cycle memory latency, redirect to 0x00400100 while a read is pending: the stale word is never output, `ireq_addr` holds the old address until `data_ok`, and the next request is 0x00400100.
- Redirect in the same cycle as `data_ok`: the returned word is dropped and 0x00400100 is requested next cycle.
- Redirect while in HOLD with `stall`=1: both buffers are flushed, `f_d_valid`=0 next cycle, and 0x00400100 is fetched.
- `reset` asserted mid-stall with a full skid buffer: `f_d_valid`=0, instruction=0, and `ireq_valid`=0 immediately; `PC_RESET` is fetched after release.

Source files
------------

// File: rtl/fetch.sv
// fetch: instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the PC, issues word reads to instruction memory over a valid/data_ok
// handshake and presents {instruction, pc_plus_4} to decode. A one-entry skid
// buffer absorbs the read that completes while decode stalls, and a DISCARD
// state drops a read that was in flight when a branch redirect arrived.
//
// Ports:
//   clk            pipeline clock
//   reset          asynchronous, active-high reset
//   ireq_valid     read request to instruction memory
//   ireq_addr      read address (word aligned)
//   iresp_data_ok  read data valid; completes the outstanding request
//   iresp_data     instruction word, valid with iresp_data_ok
//   stall          decode cannot accept this cycle
//   redirect_valid taken-branch pulse from execute
//   redirect_pc    branch target (bits [1:0] ignored)
//   f_d_reg        {instruction, pc_plus_4} to decode
//   f_d_valid      f_d_reg holds a real instruction

typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus_4;
} f_d_reg_t;

module fetch #(
    parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output f_d_reg_t    f_d_reg,
    output logic        f_d_valid
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_q, stale_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        req_pending;
    logic        consume;
    logic [31:0] pc_plus;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign req_pending = (state_q != StHold);
    assign consume     = out_valid_q && !stall;
    assign pc_plus     = pc_q + 32'd4;

    // Request is masked during reset so the memory never sees a read then.
    assign ireq_valid = req_pending && !reset;
    assign ireq_addr  = (state_q == StDiscard) ? stale_q : pc_q;

    assign f_d_valid           = out_valid_q;
    assign f_d_reg.instruction = out_valid_q ? out_instr_q : 32'h0;
    assign f_d_reg.pc_plus_4   = out_pc4_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = {redirect_pc[31:2], 2'b00};
            if (req_pending && !iresp_data_ok) begin
                state_d = StDiscard;
                // A second redirect while discarding must keep the address the
                // memory is still working on.
                if (state_q == StFetch) begin
                    stale_d = pc_q;
                end
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (iresp_data_ok) begin
                        pc_d = pc_plus;
                        if (!out_valid_q || consume) begin
                            out_valid_d = 1'b1;
                            out_instr_d = iresp_data;
                            out_pc4_d   = pc_plus;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = iresp_data;
                            skid_pc4_d   = pc_plus;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        out_valid_d  = 1'b1;
                        out_instr_d  = skid_instr_q;
                        out_pc4_d    = skid_pc4_q;
                        skid_valid_d = 1'b0;
                        state_d      = StFetch;
                    end
                end
                StDiscard: begin
                    if (iresp_data_ok) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= PC_RESET;
            stale_q      <= 32'h0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc4_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: bench for the fetch stage. The memory model returns the request
// address as the instruction word. Each test pushes the instructions decode is
// expected to consume; a monitor pops and compares on every consuming cycle.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] TGT    = 32'h0040_0100;
    localparam logic [31:0] TGT2   = 32'h0040_0200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [63:0] fdr;
    logic        f_d_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    int unsigned lat = 0;
    int unsigned cnt = 0;

    fetch #(.PC_RESET(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .f_d_reg        (fdr),
        .f_d_valid      (f_d_valid)
    );

    always #5 clk = ~clk;

    // Memory: answers each request after 'lat' extra cycles, data = address.
    always @(negedge clk) begin
        if (reset || !ireq_valid) begin
            iresp_data_ok = 1'b0;
            cnt = 0;
        end else if (cnt == lat) begin
            iresp_data_ok = 1'b1;
            iresp_data = ireq_addr;
            cnt = 0;
        end else begin
            iresp_data_ok = 1'b0;
            cnt++;
        end
    end

    // Monitor: decode consumes when valid and not stalled.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && f_d_valid && !stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: got %h, required nothing", fdr);
            end else begin
                e = exp_q.pop_front();
                if (fdr !== e) begin
                    n_bad++;
                    $display("FAIL out_word: got %h, required %h", fdr, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a);
        logic [31:0] p4;
        p4 = a + 32'd4;
        exp_q.push_back({a, p4});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic release_rst();
        step();
        reset = 1'b0;
    endtask

    task automatic end_test(input string name);
        step();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        mid();
        chk({name, "_rst_valid"}, {31'b0, f_d_valid}, 32'h0);
        chk({name, "_rst_instr"}, fdr[63:32], 32'h0);
        chk({name, "_rst_pc4"}, fdr[31:0], 32'h0);
        chk({name, "_rst_ireq"}, {31'b0, ireq_valid}, 32'h0);
    endtask

    initial begin
        mid();
        chk("init_valid", {31'b0, f_d_valid}, 32'h0);
        chk("init_ireq", {31'b0, ireq_valid}, 32'h0);

        // T1: zero-wait streaming after reset.
        lat = 0;
        for (int i = 0; i < 4; i++) push(RST_PC + 32'(4 * i));
        release_rst();
        mid();
        chk("t1_ireq_valid", {31'b0, ireq_valid}, 32'h1);
        chk("t1_addr0", ireq_addr, RST_PC);
        chk("t1_valid0", {31'b0, f_d_valid}, 32'h0);
        step(); mid();
        chk("t1_addr1", ireq_addr, RST_PC + 32'h4);
        repeat (3) step();
        end_test("t1");

        // T2: stall for 3 cycles, one word into the skid buffer.
        for (int i = 0; i < 5; i++) push(RST_PC + 32'(4 * i));
        release_rst();
        step();
        step(); stall = 1'b1;
        mid();
        chk("t2_ireq_c2", {31'b0, ireq_valid}, 32'h1);
        chk("t2_addr_c2", ireq_addr, RST_PC + 32'h8);
        step(); mid();
        chk("t2_hold_c3", {31'b0, ireq_valid}, 32'h0);
        step(); mid();
        chk("t2_hold_c4", {31'b0, ireq_valid}, 32'h0);
        step(); stall = 1'b0;
        mid();
        chk("t2_hold_c5", {31'b0, ireq_valid}, 32'h0);
        step(); mid();
        chk("t2_ireq_c6", {31'b0, ireq_valid}, 32'h1);
        chk("t2_addr_c6", ireq_addr, RST_PC + 32'hC);
        step(); step();
        end_test("t2");

        // T6: reset while in HOLD with the skid buffer full.
        push(RST_PC);
        release_rst();
        step();
        step(); stall = 1'b1;
        step(); mid();
        chk("t6_hold", {31'b0, ireq_valid}, 32'h0);
        end_test("t6mid");
        push(RST_PC);
        push(RST_PC + 32'h4);
        release_rst();
        mid();
        chk("t6_refetch", ireq_addr, RST_PC);
        chk("t6_valid0", {31'b0, f_d_valid}, 32'h0);
        step(); step();
        end_test("t6");

        // T3: 2-cycle memory, redirect while a read is pending.
        lat = 2;
        push(RST_PC);
        push(TGT);
        release_rst();
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = TGT;
        mid();
        chk("t3_addr_c4", ireq_addr, RST_PC + 32'h4);
        step(); redirect_valid = 1'b0;
        mid();
        chk("t3_valid_c5", {31'b0, f_d_valid}, 32'h0);
        chk("t3_stale_c5", ireq_addr, RST_PC + 32'h4);
        step(); mid();
        chk("t3_ireq_c6", {31'b0, ireq_valid}, 32'h1);
        chk("t3_tgt_c6", ireq_addr, TGT);
        repeat (4) step();
        end_test("t3");

        // T4: redirect in the same cycle as data_ok.
        lat = 0;
        push(RST_PC);
        push(RST_PC + 32'h4);
        push(TGT);
        push(TGT + 32'h4);
        release_rst();
        step();
        step(); redirect_valid = 1'b1; redirect_pc = TGT;
        mid();
        chk("t4_addr_c2", ireq_addr, RST_PC + 32'h8);
        step(); redirect_valid = 1'b0;
        mid();
        chk("t4_valid_c3", {31'b0, f_d_valid}, 32'h0);
        chk("t4_bubble_c3", fdr[63:32], 32'h0);
        chk("t4_pc4_hold_c3", fdr[31:0], RST_PC + 32'h8);
        chk("t4_tgt_c3", ireq_addr, TGT);
        step(); step();
        end_test("t4");

        // T5: redirect while in HOLD with stall held.
        push(RST_PC);
        push(TGT);
        push(TGT + 32'h4);
        release_rst();
        step();
        step(); stall = 1'b1;
        step(); redirect_valid = 1'b1; redirect_pc = TGT;
        mid();
        chk("t5_hold_c3", {31'b0, ireq_valid}, 32'h0);
        step(); redirect_valid = 1'b0; stall = 1'b0;
        mid();
        chk("t5_valid_c4", {31'b0, f_d_valid}, 32'h0);
        chk("t5_bubble_c4", fdr[63:32], 32'h0);
        chk("t5_tgt_c4", ireq_addr, TGT);
        step(); step();
        end_test("t5");

        // T7: redirect to the top word (low bits forced to 0), PC wraps.
        push(32'hFFFF_FFFC);
        push(32'h0000_0000);
        release_rst();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        mid();
        chk("t7_addr_c0", ireq_addr, RST_PC);
        step(); redirect_valid = 1'b0;
        mid();
        chk("t7_valid_c1", {31'b0, f_d_valid}, 32'h0);
        chk("t7_top_c1", ireq_addr, 32'hFFFF_FFFC);
        step(); mid();
        chk("t7_wrap_c2", ireq_addr, 32'h0);
        step();
        end_test("t7");

        // T8: second redirect while discarding keeps the stale address.
        lat = 3;
        push(RST_PC);
        push(TGT2);
        release_rst();
        repeat (5) step();
        redirect_valid = 1'b1; redirect_pc = TGT;
        step(); redirect_pc = TGT2;
        mid();
        chk("t8_stale_c6", ireq_addr, RST_PC + 32'h4);
        step(); redirect_valid = 1'b0;
        mid();
        chk("t8_stale_c7", ireq_addr, RST_PC + 32'h4);
        chk("t8_valid_c7", {31'b0, f_d_valid}, 32'h0);
        step(); mid();
        chk("t8_tgt2_c8", ireq_addr, TGT2);
        repeat (4) step();
        end_test("t8");

        chk("leftover_expected", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
